// File: rtl/sw_input_ctrl_pkg.sv
// Shared MMIO constants for the switch input controller.
// CPU load decoding and the bench reuse these constants.
package sw_input_ctrl_pkg;
  localparam logic [15:0] DATA_ADDR_DEF = 16'hFF00;
  localparam logic [15:0] STAT_ADDR_DEF = 16'hFF04;

  localparam int ST_NEMPTY  = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_CNT_LSB = 2;
  localparam int ST_CNT_W   = 3;
  localparam int ST_OVF     = 5;
  localparam int ST_UDF     = 6;
endpackage

// File: rtl/sw_input_ctrl_btn_debounce.sv
// Enter-button synchroniser and debouncer.
// Emits a one-cycle pulse on each accepted rising level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic push_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic          s1_q, s2_q;
  logic          lvl_q, lvl_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        lvl_d = ~lvl_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      lvl_q  <= 1'b0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= btn_i;
      s2_q   <= s1_q;
      lvl_q  <= lvl_d;
      prev_q <= lvl_q;
      cnt_q  <= cnt_d;
    end
  end

  // Built from registered state only, so the push strobe is glitch-free.
  assign push_o = lvl_q & ~prev_q;
endmodule

// File: rtl/sw_input_ctrl.sv
// Board switch input path: debounced enter button pushes switch words into
// a small FIFO that the CPU drains over MMIO, with a sticky-error status port.
module sw_input_ctrl
  import sw_input_ctrl_pkg::*;
#(
  parameter int          DATA_W          = 16,
  parameter int          DEPTH           = 4,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [15:0] DATA_ADDR       = DATA_ADDR_DEF,
  parameter logic [15:0] STAT_ADDR       = STAT_ADDR_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        sw_data,
  input  logic                     btn,
  input  logic [15:0]              read_address,
  input  logic                     read_enable,
  output logic [31:0]              read_data,
  output logic                     input_flag,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic              push;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              empty, full_w;
  logic              data_rd, stat_rd, pop, push_ok, ovf_evt, udf_evt;
  logic [31:0]       status;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk    (clk),
    .rst_n  (rst),
    .btn_i  (btn),
    .push_o (push)
  );

  assign empty   = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));
  assign data_rd = read_enable && (read_address == DATA_ADDR);
  assign stat_rd = read_enable && (read_address == STAT_ADDR);
  assign pop     = data_rd && !empty;
  assign udf_evt = data_rd && empty;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign push_ok = push && (!full_w || pop);
  assign ovf_evt = push && full_w && !pop;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop)     head_d = head_q + 1'b1;
    if (push_ok) tail_d = tail_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);
    ovf_d = ovf_evt ? 1'b1 : (stat_rd ? 1'b0 : ovf_q);
    udf_d = udf_evt ? 1'b1 : (stat_rd ? 1'b0 : udf_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[tail_q] <= sw_data;
  end

  always_comb begin
    status                            = '0;
    status[ST_NEMPTY]                 = !empty;
    status[ST_FULL]                   = full_w;
    status[ST_CNT_LSB +: ST_CNT_W]    = ST_CNT_W'(count_q);
    status[ST_OVF]                    = ovf_q;
    status[ST_UDF]                    = udf_q;
    read_data = '0;
    if (read_address == DATA_ADDR) begin
      if (!empty) read_data = 32'(mem_q[head_q]);
    end else if (read_address == STAT_ADDR) begin
      read_data = status;
    end
  end

  assign input_flag = !empty;
  assign full       = full_w;
  assign count      = count_q;
endmodule

// File: tb/tb_sw_input_ctrl.sv
// Directed bench for sw_input_ctrl with a short debounce window.
module tb_sw_input_ctrl;
  import sw_input_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw_data;
  logic        btn;
  logic [15:0] read_address;
  logic        read_enable;
  logic [31:0] read_data;
  logic        input_flag;
  logic        full;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  sw_input_ctrl #(.DATA_W(16), .DEPTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .sw_data      (sw_data),
    .btn          (btn),
    .read_address (read_address),
    .read_enable  (read_enable),
    .read_data    (read_data),
    .input_flag   (input_flag),
    .full         (full),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [15:0] d);
    sw_data = d;
    btn = 1'b1;
    step(8);
    btn = 1'b0;
    step(8);
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    read_address = DATA_ADDR_DEF;
    read_enable = 1'b1;
    #1 check(tag, read_data, exp);
    step(1);
    read_enable = 1'b0;
  endtask

  task automatic stat_read(input string tag, input logic [31:0] exp);
    read_address = STAT_ADDR_DEF;
    read_enable = 1'b1;
    #1 check(tag, read_data, exp);
    step(1);
    read_enable = 1'b0;
  endtask

  initial begin
    rst = 1'b0; btn = 1'b0; sw_data = '0; read_address = '0; read_enable = 1'b0;
    step(3);
    check("rst_count", 32'(count), 32'd0);
    check("rst_flag", 32'(input_flag), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_rdata", read_data, 32'd0);
    rst = 1'b1;
    step(1);

    read_address = STAT_ADDR_DEF;
    #1 check("idle_stat", read_data, 32'h0);
    pop_check("empty_pop", 32'h0);
    stat_read("udf_stat", 32'h40);
    read_address = STAT_ADDR_DEF;
    #1 check("udf_cleared", read_data, 32'h0);

    for (int i = 0; i < 5; i++) begin
      btn = 1'b1; step(1);
      btn = 1'b0; step(1);
    end
    step(8);
    check("bounce_count", 32'(count), 32'd0);

    sw_data = 16'hA5A5;
    btn = 1'b1;
    step(6);
    check("lat_before", 32'(count), 32'd0);
    step(1);
    check("lat_count", 32'(count), 32'd1);
    check("lat_flag", 32'(input_flag), 32'd1);
    btn = 1'b0;
    step(8);
    check("release_no_push", 32'(count), 32'd1);
    pop_check("pop_a5a5", 32'h0000A5A5);
    #1 check("pop_a5a5_cnt", 32'(count), 32'd0);

    for (int i = 1; i <= 5; i++) press(16'(i));
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd4);
    stat_read("ovf_stat", 32'h33);
    read_address = STAT_ADDR_DEF;
    #1 check("ovf_cleared", read_data, 32'h13);
    for (int i = 1; i <= 4; i++) pop_check($sformatf("fifo_pop%0d", i), 32'(i));
    #1 check("drain_count", 32'(count), 32'd0);
    check("drain_flag", 32'(input_flag), 32'd0);
    read_address = DATA_ADDR_DEF;
    #1 check("word5_lost", read_data, 32'h0);

    press(16'h0011); press(16'h0022); press(16'h0033); press(16'h0044);
    sw_data = 16'h0BEE;
    btn = 1'b1;
    step(6);
    pop_check("simul_pop", 32'h0011);
    #1 check("simul_count", 32'(count), 32'd4);
    read_address = STAT_ADDR_DEF;
    #1 check("simul_stat", read_data, 32'h13);
    btn = 1'b0;
    step(8);
    pop_check("simul_p2", 32'h0022);
    pop_check("simul_p3", 32'h0033);
    pop_check("simul_p4", 32'h0044);
    pop_check("simul_beee", 32'h0BEE);

    sw_data = 16'h0077;
    btn = 1'b1;
    step(6);
    pop_check("empty_simul_pop", 32'h0);
    read_address = STAT_ADDR_DEF;
    #1 check("empty_simul_stat", read_data, 32'h45);
    btn = 1'b0;
    step(8);
    stat_read("empty_simul_clr", 32'h45);
    pop_check("empty_simul_word", 32'h0077);

    press(16'h0001); press(16'h0002); press(16'h0003);
    check("pre_rst_count", 32'(count), 32'd3);
    sw_data = 16'h5A5A;
    btn = 1'b1;
    step(3);
    #2 rst = 1'b0;
    #1 check("async_count", 32'(count), 32'd0);
    check("async_flag", 32'(input_flag), 32'd0);
    @(negedge clk);
    step(1);
    rst = 1'b1;
    step(6);
    check("requal_before", 32'(count), 32'd0);
    step(1);
    check("requal_count", 32'(count), 32'd1);
    read_address = DATA_ADDR_DEF;
    #1 check("requal_data", read_data, 32'h5A5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
